// File: rtl/display_contador_mux.sv
// Purpose: BCD/hex up-counter with a time-multiplexed, active-low 7-segment scan output.
// Latency: valor/desborde one edge after inc/clr; segmentos/anodos one edge after index/valor.
// Backpressure: none; inc is sampled every cycle and the scan free-runs.
module display_contador_mux #(
    parameter int DIGITOS      = 4,
    parameter int DIV_REFRESCO = 50000,
    parameter int MODO_HEX     = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   clr,
    input  logic                   blank_ceros,
    output logic [4*DIGITOS-1:0]   valor,
    output logic                   desborde,
    output logic [6:0]             segmentos,
    output logic [DIGITOS-1:0]     anodos
);

    localparam int PW = (DIV_REFRESCO > 2) ? $clog2(DIV_REFRESCO) : 1;
    localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [PW-1:0]          pre;
    logic [IW-1:0]          idx;
    logic [4*DIGITOS-1:0]   valor_inc;
    logic                   wrap;
    logic [3:0]             nib;
    logic                   blank_sel;
    logic [DIGITOS:0]       zero_from;
    logic [6:0]             seg_nxt;
    logic [DIGITOS-1:0]     an_nxt;

    // Incremented counter value and wrap flag, BCD ripple or plain binary.
    always_comb begin
        logic                 carry;
        logic [3:0]           d;
        logic [4*DIGITOS:0]   sum;
        valor_inc = '0;
        wrap      = 1'b0;
        carry     = 1'b1;
        d         = '0;
        sum       = '0;
        if (MODO_HEX != 0) begin
            sum       = {1'b0, valor} + {{(4*DIGITOS){1'b0}}, 1'b1};
            valor_inc = sum[4*DIGITOS-1:0];
            wrap      = sum[4*DIGITOS];
        end else begin
            for (int i = 0; i < DIGITOS; i++) begin
                d = valor[4*i +: 4];
                if (carry) begin
                    if (d >= 4'd9) begin
                        valor_inc[4*i +: 4] = 4'd0;
                    end else begin
                        valor_inc[4*i +: 4] = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    valor_inc[4*i +: 4] = d;
                end
            end
            wrap = carry;
        end
    end

    // Counter register: clear wins over increment; desborde flags only a real wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valor    <= '0;
            desborde <= 1'b0;
        end else if (clr) begin
            valor    <= '0;
            desborde <= 1'b0;
        end else if (inc) begin
            valor    <= valor_inc;
            desborde <= wrap;
        end else begin
            desborde <= 1'b0;
        end
    end

    // Refresh prescaler and digit index; index steps on the prescaler terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PW'(DIV_REFRESCO - 1)) begin
            pre <= '0;
            if (idx == IW'(DIGITOS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Select the current nibble, its anode pattern and whether it is a leading zero.
    always_comb begin
        nib       = '0;
        blank_sel = 1'b0;
        an_nxt    = '1;
        zero_from = '0;
        zero_from[DIGITOS] = 1'b1;
        for (int i = DIGITOS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (valor[4*i +: 4] == 4'd0);
        end
        for (int i = 0; i < DIGITOS; i++) begin
            if (idx == IW'(i)) begin
                nib       = valor[4*i +: 4];
                an_nxt[i] = 1'b0;
                if (i > 0 && blank_ceros && zero_from[i]) begin
                    blank_sel = 1'b1;
                end
            end
        end
    end

    // Glyph decode to active-low segments (bit0 = a ... bit6 = g).
    always_comb begin
        seg_nxt = SEG_BLANK;
        case (nib)
            4'h0: seg_nxt = 7'b1000000;
            4'h1: seg_nxt = 7'b1111001;
            4'h2: seg_nxt = 7'b0100100;
            4'h3: seg_nxt = 7'b0110000;
            4'h4: seg_nxt = 7'b0011001;
            4'h5: seg_nxt = 7'b0010010;
            4'h6: seg_nxt = 7'b0000010;
            4'h7: seg_nxt = 7'b1111000;
            4'h8: seg_nxt = 7'b0000000;
            4'h9: seg_nxt = 7'b0011000;
            4'hA: seg_nxt = (MODO_HEX != 0) ? 7'b0001000 : SEG_BLANK;
            4'hB: seg_nxt = (MODO_HEX != 0) ? 7'b0000011 : SEG_BLANK;
            4'hC: seg_nxt = (MODO_HEX != 0) ? 7'b1000110 : SEG_BLANK;
            4'hD: seg_nxt = (MODO_HEX != 0) ? 7'b0100001 : SEG_BLANK;
            4'hE: seg_nxt = (MODO_HEX != 0) ? 7'b0000110 : SEG_BLANK;
            4'hF: seg_nxt = (MODO_HEX != 0) ? 7'b0001110 : SEG_BLANK;
            default: seg_nxt = SEG_BLANK;
        endcase
        if (blank_sel) begin
            seg_nxt = SEG_BLANK;
        end
    end

    // Display outputs registered together so anodos and segmentos always match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodos    <= '1;
            segmentos <= SEG_BLANK;
        end else begin
            anodos    <= an_nxt;
            segmentos <= seg_nxt;
        end
    end

endmodule

// File: doc/display_contador_mux.md
DISPLAY_CONTADOR_MUX -- requirements
Module: display_contador_mux

Interface
REQ-001 Parameter DIGITOS, default 4, range 1..8: number of counter digits and multiplexed display positions.
REQ-002 Parameter DIV_REFRESCO, default 50000, min 2: clk cycles each digit stays selected.
REQ-003 Parameter MODO_HEX, default 0: 0 = BCD counting with decimal glyphs; 1 = binary nibble counting with hex glyphs A-F.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 inc  input  1  count request; one increment per clk cycle sampled high.
REQ-007 clr  input  1  synchronous clear of the counter to zero.
REQ-008 blank_ceros  input  1  1 = suppress leading zeros.
REQ-009 valor  output  4*DIGITOS  registered counter value; nibble i = digit i, digit 0 least significant.
REQ-010 desborde  output  1  one-cycle pulse on counter wrap.
REQ-011 segmentos  output  7  active-low segments: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-012 anodos  output  DIGITOS  active-low digit select; exactly one bit low after the first post-reset update.

Function
REQ-013 Counter: in cycles with clr=1, valor SHALL become 0 next edge; clr has priority over inc.
REQ-014 MODO_HEX=0: inc=1 SHALL add 1 in BCD; digit 9 becomes 0 and carries into the next digit; no nibble ever holds 10-15.
REQ-015 MODO_HEX=1: inc=1 SHALL add 1 to valor as one 4*DIGITOS-bit binary value.
REQ-016 Wrap: increment from all-9s (BCD) or all-F (hex) SHALL yield 0 and assert desborde for exactly that edge's following cycle; desborde=0 otherwise, including on clr.
REQ-017 Prescaler: counts 0..DIV_REFRESCO-1 continuously; at terminal count the digit index SHALL advance 0,1,..,DIGITOS-1, then back to 0.
REQ-018 DIGITOS=1: index stays 0; anodos stays 1'b0 after first update.
REQ-019 anodos SHALL be registered: bit[index] = 0, all other bits = 1.
REQ-020 segmentos SHALL be registered in the same edge as anodos, encoding nibble[index] of the valor register as it stands in that cycle; latency from a valor change to visible segments is 1 cycle while that digit is selected.
REQ-021 Active-high glyph set (output = its bitwise inverse): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcfg.
REQ-022 MODO_HEX=1 adds: A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
REQ-023 Blank glyph = segmentos 7'b1111111; used for a blanked digit and, in MODO_HEX=0, for any nibble 10-15 (unreachable in normal operation).
REQ-024 Leading-zero suppression: with blank_ceros=1, digit i>0 SHALL be blank when nibble i and all higher nibbles are 0; digit 0 is never blanked.
REQ-025 inc, clr and the scan advance SHALL operate independently; simultaneous inc and terminal count SHALL both take effect on the same edge.

Reset
REQ-026 While rst_n=0: valor=0, desborde=0, prescaler=0, index=0, anodos all 1, segmentos 7'b1111111, immediately and independent of clk.
REQ-027 First rising edge after rst_n deasserts SHALL load anodos with bit0 low and segmentos with digit 0's glyph; prescaler starts counting from 0 on that edge.
REQ-028 Reset mid-count or mid-scan SHALL discard all state; no desborde pulse is produced by reset.

Verification
REQ-029 DIGITOS=4, MODO_HEX=0, DIV_REFRESCO=4: reset, no inc -> anodos cycles 1110,1101,1011,0111 each held 4 cycles; segmentos 7'b1000000 (glyph 0) on every digit.
REQ-030 BCD carry: load 0099 via 99 inc pulses, one more inc -> valor 16'h0100, desborde stays 0; digit 1 shows 7'b1000000.
REQ-031 Wrap: valor 16'h9999 plus one inc -> valor 0, desborde high exactly one cycle; MODO_HEX=1 at 16'hFFFF -> same behaviour.
REQ-032 Glyph sweep MODO_HEX=1: digit 0 stepped 0..F -> segmentos match REQ-021/022 inverse, e.g. 9 -> 7'b0011000, A -> 7'b0001000, F -> 7'b0001110.
REQ-033 blank_ceros=1, valor 16'h0040 -> digits 3,2 show 7'b1111111, digit 1 shows 4 (7'b0011001), digit 0 shows 0; valor 0 -> only digit 0 lit with 0.
REQ-034 inc and clr high together at valor 16'h0005 -> valor 0 next cycle; rst_n pulsed low mid-scan -> anodos all 1, segmentos 7'b1111111 asynchronously, restart at digit 0.
